datapath_seq: RTL and testbench
===============================

# datapath_seq

Parametrised, self-sequencing successor to the lab datapath. It holds an NREG x W register file, A/B/C pipeline registers, a shifter, an ALU and a status register. It also contains an internal micro-sequencer, so one handshaked command executes a complete register-to-register operation without an external controller driving loada/loadb/loadc/write. It sits where the datapath sits today, with the future CPU FSM issuing commands instead of raw control bits.

## Interface
- W, default 16: data width; must be ≥ 8.
- NREG, default 8: number of registers; power of two, ≥ 2. RW = $clog2(NREG) is derived, not overridable.
- clk, input, 1: sole clock; every state element updates on the rising edge.
- reset, input, 1: asynchronous, active-high. It clears all state immediately.
- cmd_valid, input, 1: a command is presented.
- cmd_ready, output, 1: the sequencer is IDLE. A command is accepted on a rising edge where cmd_valid && cmd_ready.
- cmd_op, input, 3: 000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 110/111 illegal.
- cmd_rd, cmd_rn, cmd_rm, input, RW each: destination and source register indices.
- cmd_shift, input, 2: shift applied to the Rm operand. 00 none, 01 LSL1 (zero fill), 10 LSR1 (zero fill), 11 ASR1 (MSB replicated).
- cmd_imm, input, 8: MOVI immediate, sign-extended to W.
- done, output, 1: one-cycle pulse when a command retires.
- err, output, 1: one-cycle pulse coincident with done, for illegal ops only.
- datapath_out, output, W: C register.
- N, V, Z, output, 1 each: status register.
- dbg_addr, input, RW: debug read index.
- dbg_data, output, W: combinational read of register dbg_addr.

## Operation
- All command fields are captured into internal registers at acceptance. Inputs may change freely afterwards.
- States: IDLE, RDA, RDB, EXEC, WB, plus a RETIRE flag that drives done/err.
- IDLE on acceptance:
  - MOVI goes to WB.
  - Ops 001–101 go to RDA.
  - Illegal ops stay in IDLE and pulse done and err on the next cycle, with no architectural change.
- RDA: A ← R[rn].
- RDB: B ← R[rm].
- EXEC: C ← ALU(Ain, Bin). Bin is shift(B).
  - MOV: Ain = 0, ADD.
  - ADD: A + Bin.
  - CMP: A − Bin.
  - AND: A & Bin.
  - MVN: ~Bin, A ignored.
  - Arithmetic is modulo 2^W.
- EXEC status update, CMP only:
  - Z = (result == 0).
  - N = result[W−1].
  - V = signed overflow of A − Bin, i.e. operand signs differ and result sign ≠ A sign.
  - All other ops leave N/V/Z unchanged.
- WB: write R[rd] with C for MOV/ADD/AND/MVN, or with sext(cmd_imm) for MOVI. CMP writes nothing; C still holds the difference. MOVI does not alter C. Next state is IDLE with done pulsed.
- rd may equal rn and/or rm. Reads happen in RDA/RDB, before WB, so the old values are used.
- dbg_data shows the pre-write value during the WB cycle and the new value from the following cycle.
- cmd_ready is low in every non-IDLE state. cmd_valid is ignored there; it is not queued.

## Timing
- Reset values: all registers 0, A/B/C 0, N=V=Z=0, state IDLE. cmd_ready=1, done=0, err=0, datapath_out=0.
- Reset asserted mid-command aborts it. No register write occurs on or after the asserting edge, and no done is pulsed.
- Acceptance at edge k is followed by these states and retire cycles:
  - MOVI: WB during cycle k+1; done high and cmd_ready high in cycle k+2.
  - ALU ops: RDA k+1, RDB k+2, EXEC k+3, WB k+4; done and cmd_ready high in cycle k+5.
  - Illegal: done/err high in cycle k+1, cmd_ready stays 1.
- A new command may be accepted in the same cycle done is high, giving back-to-back throughput of one command per 2 cycles (MOVI) or 5 cycles (ALU).
- done and err are registered, exactly one cycle wide, never high while reset is high.

## Test plan
- Reset then MOVI R3,#−2 (W=16) -> done 2 cycles after accept; dbg_addr=3 reads 0xFFFE; datapath_out stays 0.
- R1=5, R2=3; ADD R0,R1,R2 with LSL1 -> done at k+5; R0=11; datapath_out=11; N/V/Z unchanged (0,0,0).
- R1=0x7FFF, R2=0xFFFF; CMP R1,R2 -> N=1, V=1, Z=0; no register written; cmd_valid held high during busy is ignored.
- ASR1 MOV R4,R5 with R5=0x8002 -> R4=0xC001. MVN R6,R6 with R6=0x00FF -> R6=0xFF00 (self-reference).
- cmd_op=111 -> done and err high in cycle k+1, all registers and flags unchanged. Then reset asserted during EXEC of ADD R0 -> no write, done never pulses, all outputs 0.
- Re-run the ADD and CMP cases with W=8, NREG=4 -> identical semantics; CMP 0x7F − 0xFF gives V=1, N=1.

Source files
------------

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, A/B/C pipeline registers, shifter, ALU and
// status flags. A micro-sequencer runs each handshaked command to completion.
module datapath_seq #(
  parameter  int W    = 16,
  parameter  int NREG = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_rn,
  input  logic [RW-1:0] cmd_rm,
  input  logic [1:0]    cmd_shift,
  input  logic [7:0]    cmd_imm,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  datapath_out,
  output logic          N,
  output logic          V,
  output logic          Z,
  input  logic [RW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  localparam logic [2:0] OP_MOVI = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_CMP  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_MVN  = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_rf [NREG];
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_c;
  logic          r_n;
  logic          r_v;
  logic          r_z;
  logic [2:0]    r_op;
  logic [RW-1:0] r_rd;
  logic [RW-1:0] r_rn;
  logic [RW-1:0] r_rm;
  logic [1:0]    r_shift;
  logic [7:0]    r_imm;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic          w_load_a;
  logic          w_load_b;
  logic          w_load_c;
  logic          w_wb_en;
  logic          w_done_next;
  logic          w_err_next;
  logic [W-1:0]  w_bin;
  logic [W-1:0]  w_alu;
  logic          w_ovf;
  logic signed [7:0] w_imm_s;
  logic [W-1:0]  w_imm_ext;
  logic [W-1:0]  w_wb_data;

  assign cmd_ready = (r_state == S_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  // Illegal ops never leave IDLE; they only schedule the done/err pulse.
  always_comb begin
    w_state_next = r_state;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_c     = 1'b0;
    w_wb_en      = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_op == OP_MOVI) begin
            w_state_next = S_WB;
          end else if (cmd_op <= OP_MVN) begin
            w_state_next = S_RDA;
          end else begin
            w_done_next = 1'b1;
            w_err_next  = 1'b1;
          end
        end
      end
      S_RDA: begin
        w_load_a     = 1'b1;
        w_state_next = S_RDB;
      end
      S_RDB: begin
        w_load_b     = 1'b1;
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        w_load_c     = 1'b1;
        w_state_next = S_WB;
      end
      S_WB: begin
        w_wb_en      = (r_op != OP_CMP);
        w_done_next  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= '0;
      r_rd    <= '0;
      r_rn    <= '0;
      r_rm    <= '0;
      r_shift <= '0;
      r_imm   <= '0;
    end else if (w_accept) begin
      r_op    <= cmd_op;
      r_rd    <= cmd_rd;
      r_rn    <= cmd_rn;
      r_rm    <= cmd_rm;
      r_shift <= cmd_shift;
      r_imm   <= cmd_imm;
    end
  end

  always_comb begin
    w_bin = r_b;
    case (r_shift)
      2'b01:   w_bin = {r_b[W-2:0], 1'b0};
      2'b10:   w_bin = {1'b0, r_b[W-1:1]};
      2'b11:   w_bin = {r_b[W-1], r_b[W-1:1]};
      default: w_bin = r_b;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_MOV:  w_alu = w_bin;
      OP_ADD:  w_alu = r_a + w_bin;
      OP_CMP:  w_alu = r_a - w_bin;
      OP_AND:  w_alu = r_a & w_bin;
      OP_MVN:  w_alu = ~w_bin;
      default: w_alu = '0;
    endcase
  end

  // Subtraction overflows when operand signs differ and the result sign flips away from A.
  assign w_ovf = (r_a[W-1] != w_bin[W-1]) && (w_alu[W-1] != r_a[W-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_n <= 1'b0;
      r_v <= 1'b0;
      r_z <= 1'b0;
    end else begin
      if (w_load_a) r_a <= r_rf[r_rn];
      if (w_load_b) r_b <= r_rf[r_rm];
      if (w_load_c) begin
        r_c <= w_alu;
        if (r_op == OP_CMP) begin
          r_n <= w_alu[W-1];
          r_v <= w_ovf;
          r_z <= (w_alu == '0);
        end
      end
    end
  end

  assign w_imm_s   = r_imm;
  assign w_imm_ext = W'(w_imm_s);
  assign w_wb_data = (r_op == OP_MOVI) ? w_imm_ext : r_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_wb_en) begin
      r_rf[r_rd] <= w_wb_data;
    end
  end

  assign dbg_data     = r_rf[dbg_addr];
  assign datapath_out = r_c;
  assign N            = r_n;
  assign V            = r_v;
  assign Z            = r_z;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_datapath_seq.sv
// Drives identical commands into a W=16/NREG=8 and a W=8/NREG=4 instance and checks both
// against arithmetic reference models of the command semantics.
module tb_datapath_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [2:0] cmd_rd = '0;
  logic [2:0] cmd_rn = '0;
  logic [2:0] cmd_rm = '0;
  logic [1:0] cmd_shift = '0;
  logic [7:0] cmd_imm = '0;
  logic [2:0] dbg_addr = '0;

  logic        ready_a, done_a, err_a, n_a, v_a, z_a;
  logic [15:0] out_a, dbg_a;
  logic        ready_b, done_b, err_b, n_b, v_b, z_b;
  logic [7:0]  out_b, dbg_b;

  int checks = 0;
  int failures = 0;

  int ma [8];
  int mb [4];
  int ca, cb;
  bit na, va, za, nb, vb, zb;

  always #5 clk = ~clk;

  datapath_seq dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_shift(cmd_shift), .cmd_imm(cmd_imm), .done(done_a), .err(err_a),
    .datapath_out(out_a), .N(n_a), .V(v_a), .Z(z_a),
    .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  datapath_seq #(.W(8), .NREG(4)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd[1:0]), .cmd_rn(cmd_rn[1:0]), .cmd_rm(cmd_rm[1:0]),
    .cmd_shift(cmd_shift), .cmd_imm(cmd_imm), .done(done_b), .err(err_b),
    .datapath_out(out_b), .N(n_b), .V(v_b), .Z(z_b),
    .dbg_addr(dbg_addr[1:0]), .dbg_data(dbg_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Command semantics with plain signed/unsigned integer arithmetic at width w.
  function automatic void ref_exec(input int w, input int op, input int a, input int b,
                                   input int sh, output int res, output bit n,
                                   output bit v, output bit z);
    int mask, half, sa, sb, bin, sbin, diff;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    case (sh)
      1:       bin = (b * 2) & mask;
      2:       bin = b / 2;
      3:       bin = (sb >>> 1) & mask;
      default: bin = b;
    endcase
    sbin = (bin >= half) ? bin - (1 << w) : bin;
    case (op)
      1:       res = bin;
      2:       res = (a + bin) & mask;
      3:       res = (a - bin) & mask;
      4:       res = a & bin;
      default: res = (~bin) & mask;
    endcase
    diff = sa - sbin;
    v = (diff < -half) || (diff > half - 1);
    n = (res >= half);
    z = (res == 0);
  endfunction

  task automatic run(input int op, input int rd, input int rn, input int rm,
                     input int sh, input int imm, input bit hold);
    int lat, n, old_a, old_b, ra, rb;
    bit wr, seen, fn, fv, fz;
    lat = (op == 0) ? 2 : ((op <= 5) ? 5 : 1);
    wr = (op <= 5) && (op != 3);
    old_a = ma[rd];
    old_b = mb[rd % 4];
    chk("ready_idle", {ready_a, ready_b}, 2'b11);
    cmd_op = op[2:0]; cmd_rd = rd[2:0]; cmd_rn = rn[2:0]; cmd_rm = rm[2:0];
    cmd_shift = sh[1:0]; cmd_imm = imm[7:0]; dbg_addr = rd[2:0];
    cmd_valid = 1'b1;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (!hold) cmd_valid = 1'b0;
      if (wr && n == lat - 1) begin
        chk("wb_old_a", dbg_a, old_a);
        chk("wb_old_b", dbg_b, old_b);
      end
      if (done_a) seen = 1'b1;
    end
    cmd_valid = 1'b0;
    chk("latency", n, lat);
    chk("done_b", done_b, 1);
    chk("err", {err_a, err_b}, (op > 5) ? 2'b11 : 2'b00);
    chk("ready_done", {ready_a, ready_b}, 2'b11);

    if (op == 0) begin
      ma[rd] = (imm >= 128) ? (imm | 16'hFF00) : imm;
      mb[rd % 4] = imm;
    end else if (op <= 5) begin
      ref_exec(16, op, ma[rn], ma[rm], sh, ra, fn, fv, fz);
      ca = ra;
      if (op == 3) begin na = fn; va = fv; za = fz; end
      ref_exec(8, op, mb[rn % 4], mb[rm % 4], sh, rb, fn, fv, fz);
      cb = rb;
      if (op == 3) begin nb = fn; vb = fv; zb = fz; end
      if (wr) begin
        ma[rd] = ra;
        mb[rd % 4] = rb;
      end
    end

    #1;
    chk("rd_a", dbg_a, ma[rd]);
    chk("rd_b", dbg_b, mb[rd % 4]);
    chk("out_a", out_a, ca);
    chk("out_b", out_b, cb);
    chk("nvz_a", {n_a, v_a, z_a}, {na, va, za});
    chk("nvz_b", {n_b, v_b, z_b}, {nb, vb, zb});
    $display("txn op=%0d rd=%0d rn=%0d rm=%0d sh=%0d imm=%02h hold=%0d lat=%0d | A: R%0d=%04h C=%04h NVZ=%0d%0d%0d | B: R%0d=%02h C=%02h NVZ=%0d%0d%0d",
             op, rd, rn, rm, sh, imm, hold, n, rd, dbg_a, out_a, n_a, v_a, z_a,
             rd % 4, dbg_b, out_b, n_b, v_b, z_b);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      chk({tag, "_a"}, dbg_a, ma[i]);
      if (i < 4) chk({tag, "_b"}, dbg_b, mb[i]);
    end
    @(negedge clk);
  endtask

  task automatic expect_reg(input int idx, input int val);
    dbg_addr = idx[2:0];
    #1;
    chk("plan_reg", dbg_a, val);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) ma[i] = 0;
    for (int i = 0; i < 4; i++) mb[i] = 0;
    ca = 0; cb = 0;
    na = 0; va = 0; za = 0; nb = 0; vb = 0; zb = 0;
  endtask

  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_ready", {ready_a, ready_b}, 2'b11);
    chk("rst_done_err", {done_a, err_a, done_b, err_b}, 4'b0000);
    chk("rst_out", {out_a, out_b}, 24'h0);
    chk("rst_flags", {n_a, v_a, z_a, n_b, v_b, z_b}, 6'b0);
    reset = 1'b0;
    check_all("rst_reg");

    // MOVI with negative immediate
    run(0, 3, 0, 0, 0, 8'hFE, 0);
    expect_reg(3, 16'hFFFE);
    chk("movi_out", out_a, 0);

    // ADD with LSL1
    run(0, 1, 0, 0, 0, 5, 0);
    run(0, 2, 0, 0, 0, 3, 0);
    run(2, 0, 1, 2, 1, 0, 0);
    expect_reg(0, 11);
    chk("add_flags", {n_a, v_a, z_a}, 3'b000);

    // CMP 0x7FFF - 0xFFFF (0x7F - 0xFF at W=8), valid held high while busy
    run(0, 1, 0, 0, 0, 8'hFF, 0);
    run(1, 1, 0, 1, 2, 0, 0);
    run(0, 2, 0, 0, 0, 8'hFF, 0);
    run(3, 0, 1, 2, 0, 0, 1);
    chk("cmp_flags_a", {n_a, v_a, z_a}, 3'b110);
    chk("cmp_flags_b", {n_b, v_b, z_b}, 3'b110);
    expect_reg(0, 11);

    // Build 0x8002 then ASR1 into R4; build 0x00FF then MVN in place
    run(0, 6, 0, 0, 0, 8'hFE, 0);
    run(2, 5, 1, 6, 0, 0, 0);
    run(5, 5, 0, 5, 0, 0, 0);
    expect_reg(5, 16'h8002);
    run(1, 4, 0, 5, 3, 0, 0);
    expect_reg(4, 16'hC001);
    run(0, 6, 0, 0, 0, 127, 0);
    run(1, 6, 0, 6, 1, 0, 0);
    run(0, 7, 0, 0, 0, 1, 0);
    run(2, 6, 6, 7, 0, 0, 0);
    run(5, 6, 0, 6, 0, 0, 0);
    expect_reg(6, 16'hFF00);

    // Illegal ops
    run(7, 1, 2, 3, 0, 8'h55, 0);
    run(6, 2, 1, 1, 1, 8'hAA, 1);
    check_all("illegal_reg");

    // Randomized commands, mostly legal
    for (int t = 0; t < 30; t++) begin
      run(($urandom_range(0, 9) < 9) ? $urandom_range(0, 5) : $urandom_range(6, 7),
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 1));
    end
    check_all("rand_reg");

    // Reset during EXEC of ADD R0 aborts with no write and no done
    cmd_op = 3'd2; cmd_rd = 3'd0; cmd_rn = 3'd1; cmd_rm = 3'd2; cmd_shift = 2'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("abort_out", {out_a, out_b}, 24'h0);
    chk("abort_flags", {n_a, v_a, z_a, n_b, v_b, z_b}, 6'b0);
    chk("abort_ready", {ready_a, ready_b}, 2'b11);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("abort_done_in_reset", {done_a, err_a, done_b, err_b}, 4'b0000);
    end
    clear_model();
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("abort_done_after", {done_a, done_b}, 2'b00);
    end
    check_all("abort_reg");
    run(0, 5, 0, 0, 0, 8'h81, 0);
    run(2, 3, 5, 5, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
